// File: rtl/ddr_burst_packer_if.sv
// ddr_burst_packer_if: DDR user-port burst command and write-data handshake
// master drives command/data, slave is the DDR controller side.
interface ddr_burst_packer_if #(
    parameter int ADDR_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [127:0]      wdata;
    modport master (output cmd_valid, cmd_addr, wdata_valid, wdata, input cmd_ready, wdata_ready);
    modport slave  (input cmd_valid, cmd_addr, wdata_valid, wdata, output cmd_ready, wdata_ready);
endinterface

// File: rtl/ddr_burst_packer.sv
// ddr_burst_packer: packs 16-bit pixel strobes into 128-bit beats and issues fixed-length DDR burst writes
// Beats queue in a first-word-fall-through FIFO; a burst starts only once a whole burst is buffered.
module ddr_burst_packer #(
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int ADDR_W     = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start_i,
    input  logic                        pix_wr_en_i,
    input  logic [15:0]                 pix_wr_data_i,
    input  logic [ADDR_W-1:0]           ddr_max_addr_i,
    ddr_burst_packer_if.master          ddr,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2;
    localparam logic [ADDR_W+1:0] STRIDE = (ADDR_W+2)'(8 * BURST_LEN);

    logic [2:0]        cnt_q, cnt_d;
    logic [127:0]      beat_q, beat_d, push_data_q, push_data_d;
    logic              push_q, push_d;
    logic [127:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [PW:0]       level_q, level_d;
    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              restart_q, restart_d, overflow_q, overflow_d;
    logic              full, pop, wr_en, flush, wvalid, last_beat, wrap;
    logic [ADDR_W+1:0] next_addr;

    always_comb begin
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        push_d      = 1'b0;
        push_data_d = {pix_wr_data_i, beat_q[111:0]};
        if (pix_wr_en_i) begin
            beat_d[16*cnt_q +: 16] = pix_wr_data_i;
            cnt_d  = cnt_q + 3'd1;
            push_d = cnt_q == 3'd7;
        end
        if (frame_start_i) begin
            beat_d = '0;
            cnt_d  = '0;
            push_d = 1'b0;
        end
    end

    assign wvalid    = state_q == DATA;
    assign full      = level_q == (PW+1)'(FIFO_DEPTH);
    assign pop       = wvalid & ddr.wdata_ready;
    assign flush     = (state_q == IDLE) & (frame_start_i | restart_q);
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign wr_en     = push_q & ~flush & (~full | pop);
    assign level_d   = flush ? '0 : level_q + (PW+1)'(wr_en) - (PW+1)'(pop);
    assign last_beat = pop & (beat_cnt_q == BW'(BURST_LEN - 1));
    assign next_addr = {2'b00, addr_q} + STRIDE;
    assign wrap      = next_addr + STRIDE - 1'b1 > {2'b00, ddr_max_addr_i};
    assign overflow_d = frame_start_i ? 1'b0 : overflow_q | (push_q & ~flush & full & ~pop);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        restart_d  = restart_q | (frame_start_i & (state_q != IDLE));
        if (flush) begin
            addr_d    = '0;
            restart_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = level_q >= (PW+1)'(BURST_LEN) ? CMD : IDLE;
        end else if (state_q == CMD) begin
            state_d    = ddr.cmd_ready ? DATA : CMD;
            beat_cnt_d = '0;
        end else if (pop) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = last_beat ? IDLE : DATA;
            addr_d     = last_beat ? (wrap ? '0 : next_addr[ADDR_W-1:0]) : addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            beat_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            restart_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_q        <= flush ? '0 : wr_q + PW'(wr_en);
            rd_q        <= flush ? '0 : rd_q + PW'(pop);
            level_q     <= level_d;
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            restart_q   <= restart_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= push_data_q;
    end

    assign ddr.cmd_valid   = state_q == CMD;
    assign ddr.cmd_addr    = addr_q;
    assign ddr.wdata_valid = wvalid;
    assign ddr.wdata       = level_q == '0 ? '0 : mem_q[rd_q];
    assign overflow_o      = overflow_q;
    assign fifo_level_o    = level_q;
endmodule

// File: tb/tb_ddr_burst_packer.sv
// tb_ddr_burst_packer: directed stimulus with a beat/command scoreboard for ddr_burst_packer
// Expected beats and burst addresses are queued as pixels are driven and popped on each DDR handshake.
module tb_ddr_burst_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_en = 1'b0;
    logic [15:0] pix_data = '0;
    logic [23:0] max_addr = 24'hFFFFFF;
    logic        overflow;
    logic [8:0]  level;
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    logic [127:0] exp_q [$];
    logic [23:0]  ea_q [$];
    logic [127:0] m_beat = '0;
    int           m_cnt = 0;

    ddr_burst_packer_if #(.ADDR_W(24)) bus ();

    ddr_burst_packer #(.BURST_LEN(64), .FIFO_DEPTH(256), .ADDR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .pix_wr_en_i(pix_en),
        .pix_wr_data_i(pix_data), .ddr_max_addr_i(max_addr), .ddr(bus),
        .overflow_o(overflow), .fifo_level_o(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pix_en = 1'b1;
            pix_data = 16'(base + i);
            m_beat[16*m_cnt +: 16] = pix_data;
            if (m_cnt == 7) begin
                exp_q.push_back(m_beat);
                m_cnt = 0;
            end else m_cnt++;
        end
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    task automatic fstart(input bit with_pix);
        @(posedge clk); #1;
        frame_start = 1'b1;
        pix_en = with_pix;
        pix_data = 16'hDEAD;
        @(posedge clk); #1;
        frame_start = 1'b0;
        pix_en = 1'b0;
        m_cnt = 0;
        m_beat = '0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() + ea_q.size()) != 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        chk(tag, exp_q.size() + ea_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_wvalid(input string tag);
        int t = 0;
        while (bus.wdata_valid !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, bus.wdata_valid, 1);
    endtask

    initial begin
        int t, p0;
        logic pend;
        logic [23:0] pend_addr;
        bus.cmd_ready = 1'b1;
        bus.wdata_ready = 1'b1;
        pend = 1'b0;
        pend_addr = '0;
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (pend) begin
                        chk("cmd_hold_valid", bus.cmd_valid, 1);
                        chk("cmd_hold_addr", bus.cmd_addr, pend_addr);
                    end
                    pend = bus.cmd_valid & ~bus.cmd_ready;
                    pend_addr = bus.cmd_addr;
                    if (bus.cmd_valid & bus.cmd_ready) begin
                        if (ea_q.size() == 0) chk("cmd_unexpected", ea_q.size(), 1);
                        else chk("cmd_addr", bus.cmd_addr, ea_q.pop_front());
                    end
                    if (bus.wdata_valid & bus.wdata_ready) begin
                        pops++;
                        if (exp_q.size() == 0) chk("beat_unexpected", exp_q.size(), 1);
                        else chk("beat", bus.wdata, exp_q.pop_front());
                    end
                end
            end
        join_none

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_wdata_valid", bus.wdata_valid, 0);
        chk("rst_cmd_addr", bus.cmd_addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;

        // one burst per 512 pixels, none before
        ea_q.push_back(24'd0);
        send(512, 0);
        drain("t1_drain0");
        repeat (20) @(posedge clk);
        #1;
        chk("t1_no_second_cmd", bus.cmd_valid, 0);
        chk("t1_level_empty", level, 0);
        ea_q.push_back(24'd512);
        send(512, 512);
        drain("t1_drain1");

        // command stall and 50% data backpressure
        bus.cmd_ready = 1'b0;
        ea_q.push_back(24'd1024);
        send(512, 1024);
        t = 0;
        while (bus.cmd_valid !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t2_cmd_wait", bus.cmd_valid, 1);
        repeat (20) begin
            @(negedge clk);
            chk("t2_stall_valid", bus.cmd_valid, 1);
            chk("t2_stall_addr", bus.cmd_addr, 24'd1024);
        end
        @(posedge clk); #1;
        p0 = pops;
        bus.cmd_ready = 1'b1;
        t = 0;
        while ((exp_q.size() + ea_q.size()) != 0 && t < 2000) begin
            @(posedge clk); #1;
            bus.wdata_ready = ~bus.wdata_ready;
            t++;
        end
        bus.wdata_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_pop_count", pops - p0, 64);
        chk("t2_level_empty", level, 0);

        // address wrap at ddr_max_addr
        fstart(1'b0);
        max_addr = 24'd1023;
        ea_q.push_back(24'd0);
        ea_q.push_back(24'd512);
        ea_q.push_back(24'd0);
        send(1536, 16'h2000);
        drain("t3_drain");
        max_addr = 24'hFFFFFF;

        // partial beat and 8th pixel discarded by frame_start in IDLE
        send(5, 16'h0F00);
        fstart(1'b0);
        chk("t5b_level", level, 0);
        send(7, 16'h0E00);
        fstart(1'b1);
        ea_q.push_back(24'd0);
        send(512, 16'h3000);
        drain("t5b_drain");

        // frame_start during DATA beat 10
        ea_q.push_back(24'd512);
        bus.wdata_ready = 1'b0;
        send(592, 16'h4000);
        wait_wvalid("t5a_wvalid_wait");
        @(posedge clk); #1;
        bus.wdata_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.wdata_ready = 1'b0;
        fstart(1'b0);
        chk("t5a_still_data", bus.wdata_valid, 1);
        repeat (10) void'(exp_q.pop_back());
        bus.wdata_ready = 1'b1;
        drain("t5a_drain");
        chk("t5a_flushed", level, 0);
        chk("t5a_idle", bus.cmd_valid, 0);
        ea_q.push_back(24'd0);
        send(512, 16'h5000);
        drain("t5a_restart_drain");

        // overflow with a stalled data channel
        ea_q.push_back(24'd512);
        bus.wdata_ready = 1'b0;
        send(2040, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_level_255", level, 255);
        chk("t4_no_overflow", overflow, 0);
        send(2960, 2040);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_overflow", overflow, 1);
        chk("t4_level_sat", level, 256);
        fstart(1'b0);
        chk("t4_overflow_clr", overflow, 0);
        while (exp_q.size() > 64) void'(exp_q.pop_back());
        bus.wdata_ready = 1'b1;
        drain("t4_drain");
        chk("t4_flushed", level, 0);

        // asynchronous reset mid-burst
        ea_q.push_back(24'd0);
        bus.wdata_ready = 1'b0;
        send(512, 16'h6000);
        wait_wvalid("t6_wvalid_wait");
        @(posedge clk); #1;
        bus.wdata_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.wdata_ready = 1'b0;
        #1;
        chk("t6_cmd_valid", bus.cmd_valid, 0);
        chk("t6_wdata_valid", bus.wdata_valid, 0);
        chk("t6_cmd_addr", bus.cmd_addr, 0);
        chk("t6_wdata", bus.wdata, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_level", level, 0);
        exp_q.delete();
        ea_q.delete();
        m_cnt = 0;
        m_beat = '0;
        pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.wdata_ready = 1'b1;
        ea_q.push_back(24'd0);
        send(512, 16'h7000);
        drain("t6_resume_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
